// File: rtl/memctl_refill_unit_if.sv
// Signal bundle for the refill unit: HTU request channel, external memory
// command/response port and the refill beat path toward the data array.
interface memctl_refill_unit_if #(
  parameter int ID_WIDTH   = 5,
  parameter int TAG_WIDTH  = 2,
  parameter int DATA_WIDTH = 128,
  parameter int BEAT_WIDTH = 1
);
  logic                  u_memctl_valid;
  logic                  u_memctl_ready;
  logic [2:0]            u_memctl_op;
  logic [ID_WIDTH-1:0]   u_memctl_id;
  logic [31:0]           u_memctl_addr;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [31:0]           mem_req_addr;
  logic [TAG_WIDTH-1:0]  mem_req_tag;

  logic                  mem_rsp_valid;
  logic                  mem_rsp_ready;
  logic [TAG_WIDTH-1:0]  mem_rsp_tag;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  mem_rsp_last;

  logic                  d_refill_valid;
  logic                  d_refill_ready;
  logic [ID_WIDTH-1:0]   d_refill_id;
  logic [BEAT_WIDTH-1:0] d_refill_beat;
  logic [DATA_WIDTH-1:0] d_refill_data;
  logic                  d_refill_last;

  // Every channel is valid/ready: a transfer happens on a rising clk edge
  // with both high; a producer holding valid keeps its payload stable until then.
  modport slave (
    input  u_memctl_valid, u_memctl_op, u_memctl_id, u_memctl_addr,
    output u_memctl_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_tag, mem_rsp_data, mem_rsp_last,
    output mem_rsp_ready,
    output d_refill_valid, d_refill_id, d_refill_beat, d_refill_data, d_refill_last,
    input  d_refill_ready
  );

  modport master (
    output u_memctl_valid, u_memctl_op, u_memctl_id, u_memctl_addr,
    input  u_memctl_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_tag, mem_rsp_data, mem_rsp_last,
    input  mem_rsp_ready,
    input  d_refill_valid, d_refill_id, d_refill_beat, d_refill_data, d_refill_last,
    output d_refill_ready
  );
endinterface

// File: rtl/memctl_refill_unit.sv
// Memory-controller refill responder: turns HTU requests into memory commands,
// tracks outstanding refills by tag and returns id-tagged refill beats.
module memctl_refill_unit #(
  parameter int ID_WIDTH    = 5,
  parameter int OUTSTANDING = 4,
  parameter int TAG_WIDTH   = $clog2(OUTSTANDING),
  parameter int DATA_WIDTH  = 128,
  parameter int BEATS       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memctl_refill_unit_if.slave  bus,
  output logic [TAG_WIDTH:0]   outstanding_cnt,
  output logic                 err_protocol,
  output logic                 err_illegal_op
);
  localparam int BEAT_WIDTH = $clog2(BEATS);
  localparam logic [2:0] OP_REFILL = 3'b001;
  localparam logic [2:0] OP_EVICT  = 3'b010;
  localparam logic [TAG_WIDTH:0] CNT_FULL = (TAG_WIDTH+1)'(OUTSTANDING);
  localparam logic [BEAT_WIDTH-1:0] BEAT_MAX = BEAT_WIDTH'(BEATS-1);

  logic                   req_vld;
  logic                   req_we;
  logic [31:0]            req_addr;
  logic [TAG_WIDTH-1:0]   req_tag;

  logic [OUTSTANDING-1:0] tbl_vld;
  logic [ID_WIDTH-1:0]    tbl_id [OUTSTANDING];
  logic [TAG_WIDTH:0]     cnt;

  logic                   rsp_vld;
  logic [ID_WIDTH-1:0]    rsp_id;
  logic [BEAT_WIDTH-1:0]  rsp_beat;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic                   rsp_last;
  logic [BEAT_WIDTH-1:0]  beat_cnt;

  logic                   u_ready;
  logic                   req_fire;
  logic                   op_refill;
  logic                   op_evict;
  logic                   alloc;
  logic [TAG_WIDTH-1:0]   alloc_idx;
  logic                   rsp_ready;
  logic                   rsp_fire;
  logic                   rsp_hit;
  logic                   beat_fwd;
  logic                   free;
  logic                   seq_err;

  assign u_ready   = (!req_vld || bus.mem_req_ready) && (cnt != CNT_FULL);
  assign req_fire  = bus.u_memctl_valid && u_ready;
  assign op_refill = (bus.u_memctl_op == OP_REFILL);
  assign op_evict  = (bus.u_memctl_op == OP_EVICT);
  assign alloc     = req_fire && op_refill;

  assign rsp_ready = !rsp_vld || bus.d_refill_ready;
  assign rsp_fire  = bus.mem_rsp_valid && rsp_ready;
  assign rsp_hit   = tbl_vld[bus.mem_rsp_tag];
  assign beat_fwd  = rsp_fire && rsp_hit;
  assign free      = beat_fwd && bus.mem_rsp_last;
  // Last must coincide exactly with the final beat slot of the line.
  assign seq_err   = bus.mem_rsp_last != (beat_cnt == BEAT_MAX);

  // Lowest free entry; an entry freed this cycle only becomes visible next cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = OUTSTANDING - 1; i >= 0; i--) begin
      if (!tbl_vld[i]) alloc_idx = TAG_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld  <= 1'b0;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_tag  <= '0;
    end else if (req_fire && (op_refill || op_evict)) begin
      req_vld  <= 1'b1;
      req_we   <= op_evict;
      req_addr <= bus.u_memctl_addr;
      req_tag  <= op_refill ? alloc_idx : '0;
    end else if (bus.mem_req_ready) begin
      req_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld <= '0;
      for (int i = 0; i < OUTSTANDING; i++) tbl_id[i] <= '0;
    end else begin
      if (alloc) begin
        tbl_vld[alloc_idx] <= 1'b1;
        tbl_id[alloc_idx]  <= bus.u_memctl_id;
      end
      if (free) tbl_vld[bus.mem_rsp_tag] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({alloc, free})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (beat_fwd) begin
      if (bus.mem_rsp_last || beat_cnt == BEAT_MAX) beat_cnt <= '0;
      else                                          beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
      rsp_beat <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
    end else if (beat_fwd) begin
      rsp_vld  <= 1'b1;
      rsp_id   <= tbl_id[bus.mem_rsp_tag];
      rsp_beat <= beat_cnt;
      rsp_data <= bus.mem_rsp_data;
      rsp_last <= bus.mem_rsp_last;
    end else if (bus.d_refill_ready) begin
      rsp_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_protocol   <= 1'b0;
      err_illegal_op <= 1'b0;
    end else begin
      err_protocol   <= rsp_fire && (!rsp_hit || seq_err);
      err_illegal_op <= req_fire && !op_refill && !op_evict;
    end
  end

  assign bus.u_memctl_ready = u_ready;
  assign bus.mem_req_valid  = req_vld;
  assign bus.mem_req_we     = req_we;
  assign bus.mem_req_addr   = req_addr;
  assign bus.mem_req_tag    = req_tag;
  assign bus.mem_rsp_ready  = rsp_ready;
  assign bus.d_refill_valid = rsp_vld;
  assign bus.d_refill_id    = rsp_id;
  assign bus.d_refill_beat  = rsp_beat;
  assign bus.d_refill_data  = rsp_data;
  assign bus.d_refill_last  = rsp_last;
  assign outstanding_cnt    = cnt;
endmodule

// File: tb/tb_memctl_refill_unit.sv
// Bench for memctl_refill_unit: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the refill unit.
module tb_memctl_refill_unit;
  localparam int ID_WIDTH    = 5;
  localparam int OUTSTANDING = 4;
  localparam int TAG_WIDTH   = 2;
  localparam int DATA_WIDTH  = 128;
  localparam int BEATS       = 2;
  localparam int BEAT_WIDTH  = 1;
  localparam int REQ_W       = 1 + 32 + TAG_WIDTH;
  localparam int REF_W       = ID_WIDTH + BEAT_WIDTH + DATA_WIDTH + 1;
  localparam logic [2:0] OP_REFILL = 3'b001;
  localparam logic [2:0] OP_EVICT  = 3'b010;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [TAG_WIDTH:0]   outstanding_cnt;
  logic                 err_protocol;
  logic                 err_illegal_op;

  memctl_refill_unit_if #(.ID_WIDTH(ID_WIDTH), .TAG_WIDTH(TAG_WIDTH),
                          .DATA_WIDTH(DATA_WIDTH), .BEAT_WIDTH(BEAT_WIDTH)) bus ();

  memctl_refill_unit #(.ID_WIDTH(ID_WIDTH), .OUTSTANDING(OUTSTANDING), .TAG_WIDTH(TAG_WIDTH),
                       .DATA_WIDTH(DATA_WIDTH), .BEATS(BEATS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .outstanding_cnt (outstanding_cnt),
    .err_protocol    (err_protocol),
    .err_illegal_op  (err_illegal_op)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  // transaction-level model state
  logic [REQ_W-1:0]    exp_req_q[$];
  logic [REF_W-1:0]    exp_ref_q[$];
  bit                  m_vld [OUTSTANDING];
  logic [ID_WIDTH-1:0] m_id  [OUTSTANDING];
  int                  m_cnt;
  int                  m_beat;
  bit                  m_req_vld;
  bit                  m_rsp_vld;
  int                  stim_tag;
  int                  n_fwd;

  function automatic logic [DATA_WIDTH-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    exp_req_q.delete();
    exp_ref_q.delete();
    for (int i = 0; i < OUTSTANDING; i++) begin
      m_vld[i] = 1'b0;
      m_id[i]  = '0;
    end
    m_cnt = 0; m_beat = 0; m_req_vld = 1'b0; m_rsp_vld = 1'b0; stim_tag = 0;
  endtask

  // driver tasks
  task automatic idle();
    bus.u_memctl_valid = 1'b0; bus.u_memctl_op = 3'b000;
    bus.u_memctl_id = '0;      bus.u_memctl_addr = '0;
    bus.mem_req_ready = 1'b1;  bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_tag = '0;      bus.mem_rsp_data = '0;
    bus.mem_rsp_last = 1'b0;   bus.d_refill_ready = 1'b1;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [ID_WIDTH-1:0] id, input logic [31:0] addr);
    bus.u_memctl_valid = 1'b1; bus.u_memctl_op = op;
    bus.u_memctl_id = id;      bus.u_memctl_addr = addr;
  endtask

  task automatic send_beat(input int tag, input logic [DATA_WIDTH-1:0] data, input bit last);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = TAG_WIDTH'(tag);
    bus.mem_rsp_data = data;  bus.mem_rsp_last = last;
  endtask

  // Offer the next legal beat of some outstanding line (same line until its last beat).
  task automatic pick_beat();
    int tag;
    if (m_cnt == 0) begin
      bus.mem_rsp_valid = 1'b0;
    end else begin
      tag = -1;
      if (m_beat != 0 && m_vld[stim_tag]) tag = stim_tag;
      for (int i = 0; i < OUTSTANDING && tag < 0; i++) if (m_vld[i]) tag = i;
      stim_tag = tag;
      send_beat(tag, rand_data(), m_beat == BEATS - 1);
    end
  endtask

  // One clock: called at posedge+1 with inputs applied; scoreboards the cycle.
  task automatic cycle();
    bit exp_u_ready, exp_rsp_ready, nxt_req, nxt_rsp, exp_prot, exp_ill;
    bit start_vld [OUTSTANDING];
    int tag, slot;
    #2;
    exp_u_ready   = (!m_req_vld || bus.mem_req_ready) && (m_cnt != OUTSTANDING);
    exp_rsp_ready = !m_rsp_vld || bus.d_refill_ready;
    n_checks++;
    if (bus.u_memctl_ready !== exp_u_ready) begin
      n_errors++; $display("FAIL u_memctl_ready: got %b expected %b", bus.u_memctl_ready, exp_u_ready);
    end
    n_checks++;
    if (bus.mem_rsp_ready !== exp_rsp_ready) begin
      n_errors++; $display("FAIL mem_rsp_ready: got %b expected %b", bus.mem_rsp_ready, exp_rsp_ready);
    end
    if (m_req_vld) begin
      n_checks++;
      if ({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_tag} !== exp_req_q[0]) begin
        n_errors++;
        $display("FAIL mem_req_payload: got %h expected %h",
                 {bus.mem_req_we, bus.mem_req_addr, bus.mem_req_tag}, exp_req_q[0]);
      end
    end
    if (m_rsp_vld) begin
      n_checks++;
      if ({bus.d_refill_id, bus.d_refill_beat, bus.d_refill_data, bus.d_refill_last} !== exp_ref_q[0]) begin
        n_errors++;
        $display("FAIL d_refill_payload: got %h expected %h",
                 {bus.d_refill_id, bus.d_refill_beat, bus.d_refill_data, bus.d_refill_last}, exp_ref_q[0]);
      end
    end

    nxt_req = m_req_vld && !bus.mem_req_ready;
    if (m_req_vld && bus.mem_req_ready) void'(exp_req_q.pop_front());
    nxt_rsp = m_rsp_vld && !bus.d_refill_ready;
    if (m_rsp_vld && bus.d_refill_ready) begin
      void'(exp_ref_q.pop_front());
      n_fwd++;
    end
    exp_prot = 1'b0;
    exp_ill  = 1'b0;
    start_vld = m_vld;

    if (bus.u_memctl_valid && exp_u_ready) begin
      if (bus.u_memctl_op == OP_REFILL) begin
        slot = 0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) if (!start_vld[i]) slot = i;
        m_vld[slot] = 1'b1;
        m_id[slot]  = bus.u_memctl_id;
        m_cnt++;
        exp_req_q.push_back({1'b0, bus.u_memctl_addr, TAG_WIDTH'(slot)});
        nxt_req = 1'b1;
      end else if (bus.u_memctl_op == OP_EVICT) begin
        exp_req_q.push_back({1'b1, bus.u_memctl_addr, {TAG_WIDTH{1'b0}}});
        nxt_req = 1'b1;
      end else begin
        exp_ill = 1'b1;
      end
    end

    if (bus.mem_rsp_valid && exp_rsp_ready) begin
      tag = int'(bus.mem_rsp_tag);
      if (start_vld[tag]) begin
        if (bus.mem_rsp_last != (m_beat == BEATS - 1)) exp_prot = 1'b1;
        exp_ref_q.push_back({m_id[tag], BEAT_WIDTH'(m_beat), bus.mem_rsp_data, bus.mem_rsp_last});
        nxt_rsp = 1'b1;
        if (bus.mem_rsp_last) begin
          m_vld[tag] = 1'b0;
          m_cnt--;
          m_beat = 0;
        end else begin
          m_beat = (m_beat + 1) % BEATS;
        end
      end else begin
        exp_prot = 1'b1;
      end
    end
    m_req_vld = nxt_req;
    m_rsp_vld = nxt_rsp;

    @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_req_valid !== m_req_vld) begin
      n_errors++; $display("FAIL mem_req_valid: got %b expected %b", bus.mem_req_valid, m_req_vld);
    end
    n_checks++;
    if (bus.d_refill_valid !== m_rsp_vld) begin
      n_errors++; $display("FAIL d_refill_valid: got %b expected %b", bus.d_refill_valid, m_rsp_vld);
    end
    n_checks++;
    if (outstanding_cnt !== (TAG_WIDTH+1)'(m_cnt)) begin
      n_errors++; $display("FAIL outstanding_cnt: got %0d expected %0d", outstanding_cnt, m_cnt);
    end
    n_checks++;
    if (err_protocol !== exp_prot) begin
      n_errors++; $display("FAIL err_protocol: got %b expected %b", err_protocol, exp_prot);
    end
    n_checks++;
    if (err_illegal_op !== exp_ill) begin
      n_errors++; $display("FAIL err_illegal_op: got %b expected %b", err_illegal_op, exp_ill);
    end
  endtask

  task automatic drain_all();
    int guard;
    guard = 0;
    bus.u_memctl_valid = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.d_refill_ready = 1'b1;
    while ((m_cnt != 0 || m_req_vld || m_rsp_vld) && guard < 100) begin
      pick_beat();
      cycle();
      guard++;
    end
    bus.mem_rsp_valid = 1'b0;
    n_checks++;
    if (guard >= 100) begin
      n_errors++; $display("FAIL drain_timeout: got %0d outstanding expected 0", m_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.mem_req_valid, bus.d_refill_valid, err_protocol, err_illegal_op} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.mem_req_valid, bus.d_refill_valid, err_protocol, err_illegal_op});
    end
    n_checks++;
    if (outstanding_cnt !== '0) begin
      n_errors++; $display("FAIL reset_cnt: got %0d expected 0", outstanding_cnt);
    end
  endtask

  task automatic test_refill_basic();
    logic [DATA_WIDTH-1:0] d0, d1;
    d0 = rand_data();
    d1 = rand_data();
    idle();
    drive_req(OP_REFILL, 5'd5, 32'h1000);
    cycle();
    bus.u_memctl_valid = 1'b0;
    n_checks++;
    if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_tag, bus.mem_req_addr} !== {1'b1, 1'b0, 2'd0, 32'h1000}) begin
      n_errors++;
      $display("FAIL basic_cmd: got v=%b we=%b tag=%0d addr=%h expected v=1 we=0 tag=0 addr=1000",
               bus.mem_req_valid, bus.mem_req_we, bus.mem_req_tag, bus.mem_req_addr);
    end
    n_checks++;
    if (outstanding_cnt !== 3'd1) begin
      n_errors++; $display("FAIL basic_cnt: got %0d expected 1", outstanding_cnt);
    end
    cycle();
    send_beat(0, d0, 1'b0);
    cycle();
    n_checks++;
    if ({bus.d_refill_id, bus.d_refill_beat, bus.d_refill_last, bus.d_refill_data} !== {5'd5, 1'b0, 1'b0, d0}) begin
      n_errors++;
      $display("FAIL basic_beat0: got id=%0d beat=%0d last=%b expected id=5 beat=0 last=0",
               bus.d_refill_id, bus.d_refill_beat, bus.d_refill_last);
    end
    send_beat(0, d1, 1'b1);
    cycle();
    n_checks++;
    if ({bus.d_refill_id, bus.d_refill_beat, bus.d_refill_last, bus.d_refill_data, outstanding_cnt}
        !== {5'd5, 1'b1, 1'b1, d1, 3'd0}) begin
      n_errors++;
      $display("FAIL basic_beat1: got id=%0d beat=%0d last=%b cnt=%0d expected id=5 beat=1 last=1 cnt=0",
               bus.d_refill_id, bus.d_refill_beat, bus.d_refill_last, outstanding_cnt);
    end
    bus.mem_rsp_valid = 1'b0;
    cycle();
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < OUTSTANDING; i++) begin
      drive_req(OP_REFILL, ID_WIDTH'(10 + i), 32'h4000 + 32'(i * 64));
      cycle();
      n_checks++;
      if (bus.mem_req_tag !== TAG_WIDTH'(i)) begin
        n_errors++; $display("FAIL full_tag: got %0d expected %0d", bus.mem_req_tag, i);
      end
    end
    bus.u_memctl_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.u_memctl_ready !== 1'b0) begin
      n_errors++; $display("FAIL full_ready: got %b expected 0", bus.u_memctl_ready);
    end
    send_beat(2, rand_data(), 1'b0);
    cycle();
    send_beat(2, rand_data(), 1'b1);
    cycle();
    bus.mem_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.u_memctl_ready !== 1'b1) begin
      n_errors++; $display("FAIL full_reopen: got %b expected 1", bus.u_memctl_ready);
    end
    drive_req(OP_REFILL, 5'd20, 32'h5000);
    cycle();
    bus.u_memctl_valid = 1'b0;
    n_checks++;
    if (bus.mem_req_tag !== 2'd2) begin
      n_errors++; $display("FAIL full_reuse_tag: got %0d expected 2", bus.mem_req_tag);
    end
    drain_all();
  endtask

  task automatic test_evict_stall();
    idle();
    bus.mem_req_ready = 1'b0;
    drive_req(OP_EVICT, 5'd0, 32'h2040);
    cycle();
    drive_req(OP_REFILL, 5'd7, 32'h6000);
    repeat (3) begin
      #1;
      n_checks++;
      if ({bus.u_memctl_ready, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, outstanding_cnt}
          !== {1'b0, 1'b1, 1'b1, 32'h2040, 3'd0}) begin
        n_errors++;
        $display("FAIL evict_hold: got rdy=%b v=%b we=%b addr=%h cnt=%0d expected rdy=0 v=1 we=1 addr=2040 cnt=0",
                 bus.u_memctl_ready, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, outstanding_cnt);
      end
      cycle();
    end
    bus.mem_req_ready = 1'b1;
    cycle();
    bus.u_memctl_valid = 1'b0;
    drain_all();
  endtask

  task automatic test_backpressure();
    logic [DATA_WIDTH-1:0] d0;
    int fwd_start;
    idle();
    drive_req(OP_REFILL, 5'd9, 32'h7000);
    cycle();
    bus.u_memctl_valid = 1'b0;
    cycle();
    fwd_start = n_fwd;
    d0 = rand_data();
    bus.d_refill_ready = 1'b0;
    send_beat(0, d0, 1'b0);
    cycle();
    send_beat(0, rand_data(), 1'b1);
    repeat (3) begin
      #1;
      n_checks++;
      if ({bus.mem_rsp_ready, bus.d_refill_valid, bus.d_refill_data} !== {1'b0, 1'b1, d0}) begin
        n_errors++;
        $display("FAIL bp_hold: got rsp_ready=%b valid=%b data=%h expected 0 1 %h",
                 bus.mem_rsp_ready, bus.d_refill_valid, bus.d_refill_data, d0);
      end
      cycle();
    end
    bus.d_refill_ready = 1'b1;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    repeat (2) cycle();
    n_checks++;
    if (n_fwd - fwd_start != 2) begin
      n_errors++; $display("FAIL bp_beats: got %0d beats expected 2", n_fwd - fwd_start);
    end
  endtask

  task automatic test_errors();
    idle();
    drive_req(OP_REFILL, 5'd3, 32'h8000);
    cycle();
    bus.u_memctl_valid = 1'b0;
    cycle();
    send_beat(3, rand_data(), 1'b0);
    cycle();
    n_checks++;
    if ({err_protocol, bus.d_refill_valid} !== 2'b10) begin
      n_errors++; $display("FAIL err_bad_tag: got err=%b valid=%b expected err=1 valid=0", err_protocol, bus.d_refill_valid);
    end
    send_beat(0, rand_data(), 1'b1);
    cycle();
    n_checks++;
    if ({err_protocol, bus.d_refill_valid, bus.d_refill_id, bus.d_refill_beat, outstanding_cnt}
        !== {1'b1, 1'b1, 5'd3, 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL err_early_last: got err=%b valid=%b id=%0d beat=%0d cnt=%0d expected 1 1 3 0 0",
               err_protocol, bus.d_refill_valid, bus.d_refill_id, bus.d_refill_beat, outstanding_cnt);
    end
    bus.mem_rsp_valid = 1'b0;
    drive_req(3'b110, 5'd0, 32'h0);
    cycle();
    bus.u_memctl_valid = 1'b0;
    n_checks++;
    if ({err_illegal_op, bus.mem_req_valid, err_protocol} !== 3'b100) begin
      n_errors++; $display("FAIL err_illegal: got ill=%b req_v=%b prot=%b expected 1 0 0",
                           err_illegal_op, bus.mem_req_valid, err_protocol);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    idle();
    drive_req(OP_REFILL, 5'd1, 32'h9000);
    cycle();
    drive_req(OP_REFILL, 5'd2, 32'h9040);
    cycle();
    bus.u_memctl_valid = 1'b0;
    cycle();
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    n_checks++;
    if ({bus.mem_req_valid, bus.d_refill_valid, err_protocol, err_illegal_op, outstanding_cnt} !== 7'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got req_v=%b ref_v=%b errs=%b%b cnt=%0d expected all 0",
               bus.mem_req_valid, bus.d_refill_valid, err_protocol, err_illegal_op, outstanding_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(0, rand_data(), 1'b0);
    cycle();
    n_checks++;
    if ({err_protocol, bus.d_refill_valid} !== 2'b10) begin
      n_errors++; $display("FAIL midreset_stale: got err=%b valid=%b expected err=1 valid=0", err_protocol, bus.d_refill_valid);
    end
    send_beat(1, rand_data(), 1'b1);
    cycle();
    bus.mem_rsp_valid = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    int r;
    idle();
    repeat (600) begin
      bus.u_memctl_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0)     bus.u_memctl_op = 3'($urandom_range(3, 7));
      else if (r < 4) bus.u_memctl_op = OP_EVICT;
      else            bus.u_memctl_op = OP_REFILL;
      bus.u_memctl_id    = ID_WIDTH'($urandom());
      bus.u_memctl_addr  = $urandom();
      bus.mem_req_ready  = ($urandom_range(0, 3) != 0);
      bus.d_refill_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) pick_beat();
      else bus.mem_rsp_valid = 1'b0;
      cycle();
    end
    drain_all();
    n_checks++;
    if (outstanding_cnt !== '0) begin
      n_errors++; $display("FAIL random_drain: got %0d expected 0", outstanding_cnt);
    end
  endtask

  initial begin
    n_fwd = 0;
    test_reset();
    test_refill_basic();
    test_full();
    test_evict_stall();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/memctl_refill_unit.md
Name: memctl_refill_unit

Overview:
- Downstream responder for the HTU memory-controller request channel.
- Accepts HTU memctl requests (op, cacheline id, address).
- Issues read/write commands to the external memory port.
- Tracks outstanding refills in a small tag table.
- Returns refill data beats, tagged with the originating cacheline id, toward the data array/ISU.

Parameters:
- ID_WIDTH, 5, width of the cacheline id (nlineWidth, sets*ways entries).
- OUTSTANDING, 4, number of refill tracking entries (power of 2, >=2).
- TAG_WIDTH, $clog2(OUTSTANDING), memory transaction tag width.
- DATA_WIDTH, 128, memory data beat width (clWordWidth).
- BEATS, 2, beats per cacheline (clWidth/clWordWidth, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- u_memctl_valid  in  1  request valid from HTU
- u_memctl_ready  out  1  request accepted
- u_memctl_op  in  3  3'b001 REFILL, 3'b010 EVICT, others illegal
- u_memctl_id  in  ID_WIDTH  cacheline id
- u_memctl_addr  in  32  line address
- mem_req_valid  out  1  memory command valid
- mem_req_ready  in  1  memory command accepted
- mem_req_we  out  1  1=write (EVICT), 0=read (REFILL)
- mem_req_addr  out  32  command address
- mem_req_tag  out  TAG_WIDTH  tracking entry index (0 for EVICT)
- mem_rsp_valid  in  1  read beat valid
- mem_rsp_ready  out  1  read beat accepted
- mem_rsp_tag  in  TAG_WIDTH  entry index of beat
- mem_rsp_data  in  DATA_WIDTH  beat data
- mem_rsp_last  in  1  final beat of line
- d_refill_valid  out  1  refill beat valid
- d_refill_ready  in  1  refill beat accepted
- d_refill_id  out  ID_WIDTH  cacheline id of beat
- d_refill_beat  out  $clog2(BEATS)  beat index within line
- d_refill_data  out  DATA_WIDTH  beat data
- d_refill_last  out  1  final beat
- outstanding_cnt  out  TAG_WIDTH+1  allocated entries
- err_protocol  out  1  1-cycle pulse on response protocol violation
- err_illegal_op  out  1  1-cycle pulse on illegal op accepted

Behaviour:
Interface and reset:
- Single clock clk. Reset rst_n is asynchronous and active-low.
- Reset clears all valids, table, beat counter and outstanding_cnt; all outputs 0.
- Reset mid-operation discards outstanding entries. Later responses hit invalid entries (see error handling).

Request path:
- One output register (req_vld).
- u_memctl_ready = (!req_vld || mem_req_ready) && (outstanding_cnt != OUTSTANDING). Independent of u_memctl_valid and op.
- Accept on u_memctl_valid && u_memctl_ready.
- REFILL: allocate the lowest-index free entry, taken from state at cycle start. Store id, set valid. Load register with we=0, addr, tag=entry.
- EVICT: no allocation; load register with we=1, tag=0.
- Illegal op: consumed, nothing issued, err_illegal_op pulses next cycle.
- Latency: accept at cycle N -> mem_req_valid at N+1.
- mem_req_* held stable until mem_req_ready; back-to-back accepts at full rate.

Response path:
- One output register (rsp_vld). mem_rsp_ready = !rsp_vld || d_refill_ready.
- Beats of one tag are contiguous (no interleave). A global beat counter counts 0..BEATS-1.
- Accepted beat to a valid entry loads d_refill_* next cycle:
  - d_refill_id = entry id
  - d_refill_beat = counter
  - d_refill_data = mem_rsp_data
  - d_refill_last = mem_rsp_last
- Counter increments per beat and resets to 0 on last.
- Entry freed on acceptance of its last beat.
- Free and allocate in the same cycle: the freed entry is reusable the next cycle; full-check uses state at cycle start.
- outstanding_cnt = +1 on alloc, -1 on free, unchanged on both.

Error handling:
- mem_rsp_last asserted with counter != BEATS-1, or counter == BEATS-1 without last: err_protocol pulse. Beat still forwarded. Entry freed on last; counter reset on last.
- Beat to an invalid entry: accepted (ready per rule), not forwarded, err_protocol pulse, counter unchanged.
- d_refill_* held stable while d_refill_valid && !d_refill_ready.

Test Plan:
- REFILL id=5 addr=0x1000, mem_req_ready=1 -> mem_req_valid next cycle, we=0, tag=0, outstanding_cnt=1. Two beats tag 0 -> d_refill id=5 beat 0/1, last on beat 1, outstanding_cnt=0.
- Four REFILLs with no responses -> tags 0,1,2,3; u_memctl_ready=0 after fourth. Last beat of tag 2 accepted -> ready=1 the following cycle; next REFILL gets tag 2.
- EVICT addr=0x2040 with mem_req_ready low 3 cycles -> mem_req held stable with we=1; u_memctl_ready=0 until accepted; outstanding_cnt unchanged.
- d_refill_ready=0 for 4 cycles during refill -> mem_rsp_ready=0 after first beat; data held; no beat lost or duplicated.
- Response tag 3 with no outstanding entry, then last on beat 0 of a valid entry -> err_protocol pulses twice; first beat dropped; second forwarded and entry freed.
- rst_n asserted with 2 refills outstanding -> all outputs 0, outstanding_cnt=0; subsequent old-tag beats dropped with err_protocol.
